// File: rtl/ddr2_addr_fifo_param.sv
// Command/address FIFO between the application interface and the DDR2 controller.
// Optional row/bank/chip conflict tagging is enabled by defining DDR2_AF_CONFLICT_EN.
module ddr2_addr_fifo_param #(
    parameter int unsigned ENTRY_W   = 36,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_OFFSET = 4,
    parameter int unsigned COL_W     = 10,
    parameter int unsigned ROW_W     = 13,
    parameter int unsigned BANK_W    = 2,
    parameter int unsigned CHIP_W    = 1
) (
    input  logic                       clk0,
    input  logic                       rst_n,
    input  logic [ENTRY_W-1:0]         app_af_addr,
    input  logic                       app_af_wren,
    input  logic                       ctrl_af_rden,
    output logic [ENTRY_W-1:0]         af_addr,
    output logic                       af_empty,
    output logic                       af_almost_full,
    output logic [$clog2(DEPTH):0]     af_count,
    output logic                       af_overflow,
    output logic                       af_underflow
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned FLD_HI = CHIP_W + BANK_W + ROW_W + COL_W - 1;
    localparam int unsigned AF_THR = DEPTH - AF_OFFSET;

    // Elaboration-time parameter sanity checks
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 4");
    end
    if (AF_OFFSET < 1 || AF_OFFSET > DEPTH - 1) begin : g_bad_af
        $error("AF_OFFSET must be in 1..DEPTH-1");
    end
    if (FLD_HI > ENTRY_W - 2) begin : g_bad_field
        $error("address fields overlap the conflict bit");
    end

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] in_r;
    logic               en_r;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               almost_full_r;
    logic               overflow_r;
    logic               underflow_r;
    logic               pop_ok;
    logic               commit_ok;
    logic               drop;
    logic [ENTRY_W-1:0] entry;

    // Input stage: one register between the application and the commit
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            in_r <= '0;
            en_r <= 1'b0;
        end else begin
            in_r <= app_af_addr;
            en_r <= app_af_wren;
        end
    end

`ifdef DDR2_AF_CONFLICT_EN
    logic [FLD_HI-COL_W:0] last_r;
    logic                  last_vld;
    logic                  conflict;

    always_comb begin
        conflict = !last_vld || (in_r[FLD_HI:COL_W] != last_r);
        entry    = {conflict, in_r[ENTRY_W-2:0]};
    end

    // Only accepted commits become the reference for the next comparison
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            last_r   <= '0;
            last_vld <= 1'b0;
        end else if (commit_ok) begin
            last_r   <= in_r[FLD_HI:COL_W];
            last_vld <= 1'b1;
        end
    end
`else
    always_comb begin
        entry = in_r;
    end
`endif

    // A pop on a full FIFO frees the slot the same-edge commit lands in
    always_comb begin
        pop_ok     = ctrl_af_rden && (count != '0);
        commit_ok  = en_r && ((count != CNT_W'(DEPTH)) || pop_ok);
        drop       = en_r && !commit_ok;
        count_next = count;
        case ({commit_ok, pop_ok})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (commit_ok) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            almost_full_r <= 1'b0;
            overflow_r    <= 1'b0;
            underflow_r   <= 1'b0;
        end else begin
            if (commit_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count         <= count_next;
            almost_full_r <= (count_next >= CNT_W'(AF_THR));
            if (drop) begin
                overflow_r <= 1'b1;
            end
            if (ctrl_af_rden && (count == '0)) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign af_addr        = mem[rd_ptr];
    assign af_empty       = (count == '0);
    assign af_almost_full = almost_full_r;
    assign af_count       = count;
    assign af_overflow    = overflow_r;
    assign af_underflow   = underflow_r;

endmodule

// File: tb/tb_ddr2_addr_fifo_param.sv
// Directed, table-driven bench for ddr2_addr_fifo_param (default parameters).
// Honours DDR2_AF_CONFLICT_EN when computing expected conflict bits.
module tb_ddr2_addr_fifo_param;

    localparam int unsigned ENTRY_W = 36;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned CNT_W   = 5;

`ifdef DDR2_AF_CONFLICT_EN
    localparam bit CONF_ON = 1'b1;
`else
    localparam bit CONF_ON = 1'b0;
`endif

    logic               clk0;
    logic               rst_n;
    logic [ENTRY_W-1:0] app_af_addr;
    logic               app_af_wren;
    logic               ctrl_af_rden;
    logic [ENTRY_W-1:0] af_addr;
    logic               af_empty;
    logic               af_almost_full;
    logic [CNT_W-1:0]   af_count;
    logic               af_overflow;
    logic               af_underflow;

    ddr2_addr_fifo_param dut (
        .clk0           (clk0),
        .rst_n          (rst_n),
        .app_af_addr    (app_af_addr),
        .app_af_wren    (app_af_wren),
        .ctrl_af_rden   (ctrl_af_rden),
        .af_addr        (af_addr),
        .af_empty       (af_empty),
        .af_almost_full (af_almost_full),
        .af_count       (af_count),
        .af_overflow    (af_overflow),
        .af_underflow   (af_underflow)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    typedef struct {
        logic        wren;
        logic [35:0] addr;
        logic        rden;
        logic [4:0]  exp_count;
        logic        chk_addr;
        logic [34:0] exp_lo;
        logic        exp_top_on;
        logic        exp_top_off;
    } vec_t;

    vec_t vecs [9];
    int   errors = 0;
    int   checks = 0;
    logic [34:0] model [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [4:0] cnt, input logic ovf, input logic unf);
        chk({tag, " count"}, 64'(af_count), 64'(cnt));
        chk({tag, " empty"}, 64'(af_empty), 64'(cnt == 5'd0));
        chk({tag, " almost_full"}, 64'(af_almost_full), 64'(cnt >= 5'd12));
        chk({tag, " overflow"}, 64'(af_overflow), 64'(ovf));
        chk({tag, " underflow"}, 64'(af_underflow), 64'(unf));
    endtask

    initial begin
        logic [35:0] exp_entry;
        logic [34:0] head;

        //            wren  addr             rden cnt chk  exp_lo       on    off
        vecs[0] = '{1'b1, 36'h0_0000_1234, 1'b0, 5'd0, 1'b0, 35'h0,      1'b0, 1'b0};
        vecs[1] = '{1'b0, 36'h0,           1'b0, 5'd1, 1'b1, 35'h1234,   1'b1, 1'b0};
        vecs[2] = '{1'b0, 36'h0,           1'b1, 5'd0, 1'b0, 35'h0,      1'b0, 1'b0};
        vecs[3] = '{1'b1, 36'h0_0000_0400, 1'b0, 5'd0, 1'b0, 35'h0,      1'b0, 1'b0};
        vecs[4] = '{1'b1, 36'h8_0000_0401, 1'b0, 5'd1, 1'b1, 35'h400,    1'b1, 1'b0};
        vecs[5] = '{1'b1, 36'h0_0000_0800, 1'b0, 5'd2, 1'b1, 35'h400,    1'b1, 1'b0};
        vecs[6] = '{1'b0, 36'h0,           1'b1, 5'd2, 1'b1, 35'h401,    1'b0, 1'b1};
        vecs[7] = '{1'b0, 36'h0,           1'b1, 5'd1, 1'b1, 35'h800,    1'b1, 1'b0};
        vecs[8] = '{1'b0, 36'h0,           1'b1, 5'd0, 1'b0, 35'h0,      1'b0, 1'b0};

        rst_n        = 1'b0;
        app_af_addr  = '0;
        app_af_wren  = 1'b0;
        ctrl_af_rden = 1'b0;
        repeat (3) @(posedge clk0);
        #3;
        chk_state("reset_hold", 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_state("reset", 5'd0, 1'b0, 1'b0);

        // Single write, conflict tagging and FWFT pops
        for (int i = 0; i < 9; i++) begin
            app_af_wren  = vecs[i].wren;
            app_af_addr  = vecs[i].addr;
            ctrl_af_rden = vecs[i].rden;
            tick();
            chk($sformatf("vec%0d count", i), 64'(af_count), 64'(vecs[i].exp_count));
            chk($sformatf("vec%0d empty", i), 64'(af_empty), 64'(vecs[i].exp_count == 5'd0));
            if (vecs[i].chk_addr) begin
                exp_entry = {CONF_ON ? vecs[i].exp_top_on : vecs[i].exp_top_off, vecs[i].exp_lo};
                chk($sformatf("vec%0d af_addr", i), 64'(af_addr), 64'(exp_entry));
            end
        end
        app_af_wren  = 1'b0;
        ctrl_af_rden = 1'b0;

        // Fill to 16; almost-full must track count >= 12 edge by edge
        for (int k = 0; k <= 16; k++) begin
            app_af_wren = (k < 16);
            app_af_addr = 36'(32'h1000_0000 + 32'(k));
            if (k < 16) model.push_back(35'(32'h1000_0000 + 32'(k)));
            tick();
            chk_state($sformatf("fill%0d", k), 5'(k), 1'b0, 1'b0);
        end

        // Pop and commit on the same edge while full
        app_af_wren = 1'b1;
        app_af_addr = 36'h0_0ABC_DEF0;
        tick();
        app_af_wren  = 1'b0;
        ctrl_af_rden = 1'b1;
        tick();
        ctrl_af_rden = 1'b0;
        void'(model.pop_front());
        model.push_back(35'h0_0ABC_DEF0);
        chk_state("simul", 5'd16, 1'b0, 1'b0);

        // Write into a full FIFO with no pop is dropped
        app_af_wren = 1'b1;
        app_af_addr = 36'h0_0DEA_D000;
        tick();
        app_af_wren = 1'b0;
        tick();
        chk_state("overflow", 5'd16, 1'b1, 1'b0);

        // Drain: order preserved across the pointer wrap
        for (int k = 0; k < 16; k++) begin
            head = model.pop_front();
            chk($sformatf("drain%0d data", k), 64'(af_addr[34:0]), 64'(head));
            ctrl_af_rden = 1'b1;
            tick();
            chk_state($sformatf("drain%0d", k), 5'(15 - k), 1'b1, 1'b0);
        end
        ctrl_af_rden = 1'b0;

        // Pop while empty
        ctrl_af_rden = 1'b1;
        tick();
        ctrl_af_rden = 1'b0;
        chk_state("underflow", 5'd0, 1'b1, 1'b1);

        // Async reset with entries present
        for (int k = 0; k < 6; k++) begin
            app_af_wren = (k < 5);
            app_af_addr = 36'(k);
            tick();
        end
        app_af_wren = 1'b0;
        chk_state("pre_reset", 5'd5, 1'b1, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_state("async_reset", 5'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        chk_state("after_reset", 5'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr2_addr_fifo_param.md
# ddr2_addr_fifo_param

Parametrised, single-clock command/address FIFO between the user application interface and the DDR2 controller state machine. It registers application write requests, optionally tags each entry with a row/bank/chip conflict bit, and stores entries in an inferred memory of configurable width and depth. The controller reads entries first-word-fall-through. The block adds an occupancy count, a programmable almost-full threshold and sticky overflow/underflow error flags.

## Interface
Parameters:
- ENTRY_W, 36: entry width in bits. Bit ENTRY_W-1 is the conflict bit; bits [31:29] carry the command.
- DEPTH, 16: number of entries. Must be a power of two, ≥ 4.
- AF_OFFSET, 4: almost-full asserts when free slots ≤ AF_OFFSET. Range 1..DEPTH-1.
- COL_W, 10: column address width.
- ROW_W, 13: row address width.
- BANK_W, 2: bank address width.
- CHIP_W, 1: chip-select address width.

Ports:
- clk0, input, 1: single clock; all logic on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- app_af_addr, input, ENTRY_W: application command/address.
- app_af_wren, input, 1: application write request.
- ctrl_af_rden, input, 1: controller pop of the head entry.
- af_addr, output, ENTRY_W: head entry, valid whenever af_empty = 0.
- af_empty, output, 1: FIFO holds no entries.
- af_almost_full, output, 1: registered almost-full flag.
- af_count, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- af_overflow, output, 1: sticky; set when a write is dropped.
- af_underflow, output, 1: sticky; set when a pop is attempted while empty.

## Operation
- **Input stage.** Each edge captures app_af_addr into in_r and app_af_wren into en_r. en_r clears on reset.
- **Commit.** On an edge with en_r = 1 and count < DEPTH:
  - mem[wr_ptr] ← entry.
  - wr_ptr increments.
  - last_r ← entry.
  - last_vld ← 1.
- **Read.** On an edge with ctrl_af_rden = 1 and count > 0, rd_ptr increments. af_addr = mem[rd_ptr], read asynchronously.
- **Pointers.** Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- **Occupancy.** count increments on a commit only, decrements on a pop only, and is unchanged when both occur on the same edge.
- **Empty/full.** af_empty = (count == 0), driven combinationally from the count register.
- **Simultaneous commit and pop.**
  - When full: the pop frees a slot in the same edge, so the commit is accepted.
  - When empty: the pop is rejected (underflow), the commit is accepted, and count becomes 1.
- **Overflow.** A commit attempted at count == DEPTH with no simultaneous pop is dropped and sets af_overflow. Memory and pointers are untouched.
- **Underflow.** ctrl_af_rden at count == 0 sets af_underflow. Pointers are untouched.
- **Sticky flags.** af_overflow and af_underflow clear only on reset.
- **Almost-full.** Next value = (count_next ≥ DEPTH − AF_OFFSET), where count_next is the count after the current edge's commit/pop.
- **Reset mid-operation.** Asynchronously clears pointers, count, en_r, last_vld and all flags. af_empty = 1; all other outputs are 0. Memory contents are not reset, and af_addr is don't-care while empty.

## Timing
- app_af_wren sampled at edge E0 → entry committed at E1 → af_empty falls and af_addr is valid after E1. Write-to-visible latency is 2 cycles.
- Pop: ctrl_af_rden high at edge E → af_addr shows the next entry after E, with zero added latency (FWFT).
- af_almost_full and af_count update on the same edge as the commit/pop that changes occupancy.
- Back-to-back writes and reads are sustained at one entry per cycle each.

## Configuration
- **DDR2_AF_CONFLICT_EN defined.**
  - Entry bit ENTRY_W-1 = conflict, all other bits come from in_r.
  - conflict = 1 if last_vld = 0, or if in_r[CHIP_W+BANK_W+ROW_W+COL_W-1 : COL_W] ≠ the same field of last_r.
  - Otherwise conflict = 0.
  - last_r updates only on accepted commits; dropped writes do not update it.
- **Not defined.**
  - The entry equals in_r unchanged, with bit ENTRY_W-1 passed through.
  - last_r and last_vld are not implemented.

## Test plan
- **Reset defaults.** Hold rst_n = 0, then release → af_empty = 1, af_count = 0, af_almost_full = 0, af_overflow = 0, af_underflow = 0.
- **Single write.** Write 0x0_0000_1234 with a single-cycle app_af_wren → af_empty falls 2 edges later, af_addr[34:0] = 0x1234. With the macro, bit 35 = 1 (first entry). One pop → af_empty = 1.
- **Conflict tagging.** Macro on, defaults. Write addresses 0x400, 0x401, then 0x800 → conflict bits 1, 0, 1. Macro off → bit 35 mirrors the input bit.
- **Fill, overflow and wrap.** DEPTH = 16, AF_OFFSET = 4.
  - 12 writes → af_almost_full rises on the edge where count reaches 12.
  - 17 writes → count = 16 and af_overflow = 1; the 17th entry is absent.
  - Pop all → entries come out in order and pointers wrap.
- **Simultaneous read/write.** With count = 16, pop and commit on the same edge → count stays 16, af_overflow is not set, and the new entry is read last.
- **Underflow and async reset.** Pop when empty → af_underflow = 1 and count stays 0. Assert rst_n mid-stream with count = 5 → count = 0 and af_empty = 1 immediately, without waiting for a clock edge.
